// File: rtl/hpdcache_sram_rmw_ctrl_if.sv
// Request/response and SRAM-macro bus bundle for hpdcache_sram_rmw_ctrl.
// The master modport is the environment side: it issues requests and owns
// the macro read data. The slave modport is the controller side.
interface hpdcache_sram_rmw_ctrl_if #(
  parameter int ADDR_SIZE = 7,
  parameter int DATA_SIZE = 64
);
  localparam int BE_SIZE = DATA_SIZE / 8;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0] req_wdata;
  logic [BE_SIZE-1:0]   req_wbyteenable;
  logic                 rsp_valid;
  logic [DATA_SIZE-1:0] rsp_rdata;
  logic                 sram_cs;
  logic                 sram_we;
  logic [ADDR_SIZE-1:0] sram_addr;
  logic [DATA_SIZE-1:0] sram_wdata;
  logic [DATA_SIZE-1:0] sram_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wbyteenable,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sram_cs, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wbyteenable,
    output req_ready, rsp_valid, rsp_rdata,
    output sram_cs, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );
endinterface

// File: rtl/hpdcache_sram_rmw_ctrl.sv
// Controller for a 1RW full-word SRAM macro without byte-enable pins.
// Full-mask writes and reads take one cycle; partial-mask writes become a
// two-cycle read-modify-write (read phase in IDLE, merged write in MERGE).
// Optional feature macro: HPDCACHE_SRAM_RMW_PERF_EN adds the saturating
// counters perf_rmw_cnt and perf_full_wr_cnt.
module hpdcache_sram_rmw_ctrl #(
  parameter int ADDR_SIZE = 7,
  parameter int DATA_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  hpdcache_sram_rmw_ctrl_if.slave bus
`ifdef HPDCACHE_SRAM_RMW_PERF_EN
  ,
  output logic [31:0]            perf_rmw_cnt,
  output logic [31:0]            perf_full_wr_cnt
`endif
);
  localparam int BE_SIZE = DATA_SIZE / 8;

  typedef enum logic {IDLE, MERGE} state_e;

  state_e               state_q, state_d;
  logic                 rsp_vld_p1;
  logic [ADDR_SIZE-1:0] rmw_addr_p1;
  logic [DATA_SIZE-1:0] rmw_wdata_p1;
  logic [BE_SIZE-1:0]   rmw_be_p1;

  logic                 req_ready;
  logic                 sram_cs;
  logic                 sram_we;
  logic [ADDR_SIZE-1:0] sram_addr;
  logic [DATA_SIZE-1:0] sram_wdata;
  logic                 rd_acc;
  logic                 full_wr;
  logic                 part_wr;

  // Byte-wise merge: masked bytes from new data, the rest from the old word.
  function automatic logic [DATA_SIZE-1:0] merge_bytes(
    input logic [DATA_SIZE-1:0] old_word,
    input logic [DATA_SIZE-1:0] new_word,
    input logic [BE_SIZE-1:0]   be
  );
    logic [DATA_SIZE-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_SIZE; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Next state and macro drive; everything is held quiet while rst is high.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    rd_acc     = 1'b0;
    full_wr    = 1'b0;
    part_wr    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          req_ready = 1'b1;
          if (bus.req_valid) begin
            if (!bus.req_we) begin
              rd_acc    = 1'b1;
              sram_cs   = 1'b1;
              sram_addr = bus.req_addr;
            end else if (&bus.req_wbyteenable) begin
              full_wr    = 1'b1;
              sram_cs    = 1'b1;
              sram_we    = 1'b1;
              sram_addr  = bus.req_addr;
              sram_wdata = bus.req_wdata;
            end else if (|bus.req_wbyteenable) begin
              // Read phase of the RMW; the old word arrives next cycle.
              part_wr   = 1'b1;
              sram_cs   = 1'b1;
              sram_addr = bus.req_addr;
              state_d   = MERGE;
            end
          end
        end
        MERGE: begin
          sram_cs    = 1'b1;
          sram_we    = 1'b1;
          sram_addr  = rmw_addr_p1;
          sram_wdata = merge_bytes(bus.sram_rdata, rmw_wdata_p1, rmw_be_p1);
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and read-response valid; reset drops any pending merged write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rsp_vld_p1 <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_vld_p1 <= rd_acc;
    end
  end

  // ---- p1: RMW context captured at the read phase ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_addr_p1  <= '0;
      rmw_wdata_p1 <= '0;
      rmw_be_p1    <= '0;
    end else if (part_wr) begin
      rmw_addr_p1  <= bus.req_addr;
      rmw_wdata_p1 <= bus.req_wdata;
      rmw_be_p1    <= bus.req_wbyteenable;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.sram_cs    = sram_cs;
  assign bus.sram_we    = sram_we;
  assign bus.sram_addr  = sram_addr;
  assign bus.sram_wdata = sram_wdata;
  assign bus.rsp_valid  = rsp_vld_p1;
  assign bus.rsp_rdata  = rsp_vld_p1 ? bus.sram_rdata : '0;

`ifdef HPDCACHE_SRAM_RMW_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Saturating event counters for RMW entries and full-mask writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rmw_cnt     <= '0;
      perf_full_wr_cnt <= '0;
    end else begin
      if (part_wr) perf_rmw_cnt     <= sat_inc(perf_rmw_cnt);
      if (full_wr) perf_full_wr_cnt <= sat_inc(perf_full_wr_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_hpdcache_sram_rmw_ctrl.sv
// Directed bench for hpdcache_sram_rmw_ctrl with a behavioural 1RW SRAM.
module tb_hpdcache_sram_rmw_ctrl;
  localparam int AW = 7;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  hpdcache_sram_rmw_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

`ifdef HPDCACHE_SRAM_RMW_PERF_EN
  logic [31:0] perf_rmw_cnt, perf_full_wr_cnt;
  hpdcache_sram_rmw_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_rmw_cnt(perf_rmw_cnt), .perf_full_wr_cnt(perf_full_wr_cnt));
`else
  hpdcache_sram_rmw_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Behavioural SRAM macro: read data registered one cycle after cs.
  logic [DW-1:0] mem [128];
  logic [DW-1:0] rdata_q = '0;
  always_ff @(posedge clk) begin
    if (bus.sram_cs) begin
      if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
      else             rdata_q <= mem[bus.sram_addr];
    end
  end
  assign bus.sram_rdata = rdata_q;

  typedef struct {
    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [7:0]    be;
    logic          exp_cs;
    logic          exp_swe;
    logic          exp_rsp;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vec [7];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [7:0] be);
    @(negedge clk);
    bus.req_valid       = v;
    bus.req_we          = we;
    bus.req_addr        = a;
    bus.req_wdata       = d;
    bus.req_wbyteenable = be;
    #1;
  endtask

  logic          prev_rsp;
  logic [DW-1:0] prev_rdata;

  initial begin
    // Reset with a read pending: nothing may be accepted or issued.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 7'h05;
    bus.req_wdata = '0; bus.req_wbyteenable = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {63'd0, bus.req_ready}, 64'd0);
    check("rst_cs", {63'd0, bus.sram_cs}, 64'd0);
    check("rst_we", {63'd0, bus.sram_we}, 64'd0);
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    check("rst_sram_addr", {57'd0, bus.sram_addr}, 64'd0);
`ifdef HPDCACHE_SRAM_RMW_PERF_EN
    check("rst_perf_rmw", {32'd0, perf_rmw_cnt}, 64'd0);
`endif
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Preload through full-mask writes.
    drive(1, 1, 7'h05, 64'h1122334455667788, 8'hFF);
    drive(1, 1, 7'h20, 64'h0123456789ABCDEF, 8'hFF);
    drive(1, 1, 7'h30, 64'h0, 8'hFF);
    drive(1, 1, 7'h10, 64'h0, 8'hFF);

    vec[0] = '{1'b1, 1'b0, 7'h05, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h1122334455667788};
    vec[1] = '{1'b1, 1'b1, 7'h10, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1, 1'b1, 1'b0, 64'h0};
    vec[2] = '{1'b1, 1'b0, 7'h10, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'hDEADBEEFCAFEF00D};
    vec[3] = '{1'b1, 1'b1, 7'h20, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0};
    vec[4] = '{1'b1, 1'b0, 7'h20, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h0123456789ABCDEF};
    vec[5] = '{1'b0, 1'b0, 7'h05, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0};
    vec[6] = '{1'b1, 1'b0, 7'h05, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h1122334455667788};

    prev_rsp = 1'b0;
    prev_rdata = '0;
    for (int i = 0; i < 7; i++) begin
      drive(vec[i].valid, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].be);
      check($sformatf("v%0d_ready", i), {63'd0, bus.req_ready}, 64'd1);
      check($sformatf("v%0d_cs", i), {63'd0, bus.sram_cs}, {63'd0, vec[i].exp_cs});
      check($sformatf("v%0d_we", i), {63'd0, bus.sram_we}, {63'd0, vec[i].exp_swe});
      if (vec[i].exp_cs)
        check($sformatf("v%0d_addr", i), {57'd0, bus.sram_addr}, {57'd0, vec[i].addr});
      if (vec[i].exp_swe)
        check($sformatf("v%0d_wdata", i), bus.sram_wdata, vec[i].wdata);
      check($sformatf("v%0d_prev_rsp_valid", i), {63'd0, bus.rsp_valid}, {63'd0, prev_rsp});
      if (prev_rsp)
        check($sformatf("v%0d_prev_rsp_rdata", i), bus.rsp_rdata, prev_rdata);
      prev_rsp = vec[i].exp_rsp;
      prev_rdata = vec[i].exp_rdata;
    end
    drive(0, 0, 7'h0, 64'h0, 8'h00);
    check("tail_rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, prev_rsp});
    check("tail_rsp_rdata", bus.rsp_rdata, prev_rdata);

    // Partial write, then an immediate read of the same word.
    drive(1, 1, 7'h10, 64'h1111111111111111, 8'hFF);
    drive(1, 1, 7'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    check("rmw_rd_ready", {63'd0, bus.req_ready}, 64'd1);
    check("rmw_rd_cs", {63'd0, bus.sram_cs}, 64'd1);
    check("rmw_rd_we", {63'd0, bus.sram_we}, 64'd0);
    drive(1, 0, 7'h10, 64'h0, 8'h00);
    check("merge_ready", {63'd0, bus.req_ready}, 64'd0);
    check("merge_cs", {63'd0, bus.sram_cs}, 64'd1);
    check("merge_we", {63'd0, bus.sram_we}, 64'd1);
    check("merge_addr", {57'd0, bus.sram_addr}, 64'h10);
    check("merge_wdata", bus.sram_wdata, 64'h11111111BBBBBBBB);
    check("merge_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    drive(1, 0, 7'h10, 64'h0, 8'h00);
    check("post_merge_ready", {63'd0, bus.req_ready}, 64'd1);
    check("post_merge_cs", {63'd0, bus.sram_cs}, 64'd1);
    check("post_merge_we", {63'd0, bus.sram_we}, 64'd0);
    drive(0, 0, 7'h0, 64'h0, 8'h00);
    check("merged_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    check("merged_rsp_rdata", bus.rsp_rdata, 64'h11111111BBBBBBBB);

    // Reset during MERGE drops the merged write.
    drive(1, 1, 7'h30, 64'hFFFFFFFFFFFFFFFF, 8'h01);
    check("rstm_rd_cs", {63'd0, bus.sram_cs}, 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rstm_cs", {63'd0, bus.sram_cs}, 64'd0);
    check("rstm_we", {63'd0, bus.sram_we}, 64'd0);
    check("rstm_ready", {63'd0, bus.req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef HPDCACHE_SRAM_RMW_PERF_EN
    #1;
    check("rstm_perf_rmw", {32'd0, perf_rmw_cnt}, 64'd0);
    check("rstm_perf_full", {32'd0, perf_full_wr_cnt}, 64'd0);
`endif
    drive(1, 0, 7'h30, 64'h0, 8'h00);
    check("rstm_rb_ready", {63'd0, bus.req_ready}, 64'd1);
    drive(0, 0, 7'h0, 64'h0, 8'h00);
    check("rstm_rb_valid", {63'd0, bus.rsp_valid}, 64'd1);
    check("rstm_rb_rdata", bus.rsp_rdata, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
